debouncer: RTL
==============

# debouncer

Cleans a raw, bouncing mechanical input (switch or push-button) into a stable level for the dual-edge detector stage, which consumes that level directly. An unsynchronized input passes through a two-flop synchronizer and then a four-state FSM with a down-counter. The FSM accepts a new level only after it has held steady for a programmable number of clock cycles. The block also emits a one-cycle tick on every confirmed rising transition.

## Interface
- CNT_MAX, 2_000_000, number of consecutive stable samples required after the first changed sample (20 ms at 100 MHz); legal range ≥ 2
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- sw  input  1  raw switch input, asynchronous to clk, may bounce
- db_level  output  1  debounced level; drives the downstream edge detector's level input
- db_tick  output  1  one-cycle pulse on each confirmed 0→1 transition of db_level

## Operation
- Synchronizer:
  - s1 <= sw; sw_sync <= s1.
  - Both flops reset to 0.
  - The FSM observes only sw_sync.
- Counter:
  - Width is $clog2(CNT_MAX), unsigned.
  - Loads CNT_MAX-1 on entry to a wait state.
  - Decrements by 1 per cycle while in that wait state.
  - Never wraps; it is only evaluated for 0.
- States:
  - ZERO (db_level=0): sw_sync=1 → WAIT1 and load counter; else stay.
  - WAIT1 (db_level=0):
    - sw_sync=0 → ZERO; the counter value is discarded.
    - Else if cnt=0 → ONE.
    - Else decrement and stay.
  - ONE (db_level=1): sw_sync=0 → WAIT0 and load counter; else stay.
  - WAIT0 (db_level=1):
    - sw_sync=1 → ONE.
    - Else if cnt=0 → ZERO.
    - Else decrement and stay.
- db_level is decoded from the state register only (ONE or WAIT0 → 1). There is no combinational path from sw.
- db_tick is a register:
  - Set to 1 on the edge where WAIT1 → ONE.
  - Cleared on the next edge.
  - Never asserted on a falling transition.
- Acceptance rule:
  - A new level is accepted only if sw_sync holds it for CNT_MAX+1 consecutive sampling edges: the entry edge plus CNT_MAX wait edges.
  - A run of ≤ CNT_MAX samples is rejected, and db_level stays unchanged.
- Bounce inside a wait state returns the FSM to the stable state. The next change reloads the counter from CNT_MAX-1; there is no partial credit.

## Timing
- Reset values: s1=0, sw_sync=0, state=ZERO, cnt=0, db_level=0, db_tick=0.
- Reset is asynchronous. Asserting it mid-wait returns the block to ZERO within the same cycle, with no tick.
- Latency, clean rise: sw rises before edge A (edge 1).
  - s1=1 at edge 1; sw_sync=1 at edge 2.
  - FSM enters WAIT1 at edge 3.
  - ONE, with db_level=1 and db_tick=1, at edge CNT_MAX+3.
  - db_tick drops at edge CNT_MAX+4.
- Falling latency is identical: db_level falls at edge CNT_MAX+3, with no tick.
- sw held high through reset release behaves as a rise starting at the first edge after release. db_level rises at edge CNT_MAX+3 and db_tick is asserted.
- sw_sync changing on the same edge that cnt reaches 0 follows the rules above:
  - The level check takes priority over cnt=0.
  - Therefore WAIT1 with sw_sync=0 always goes to ZERO.
- db_tick is never asserted for two consecutive cycles.
- Minimum spacing between ticks is 2·(CNT_MAX+1) cycles.

## Test plan
All scenarios use CNT_MAX=4 and clock period T=20. Apply reset for half a period, then drive sw on negedges.
- Clean press:
  - Stimulus: sw 0→1 and held.
  - Required: db_level rises exactly at the 7th rising edge after the change, and db_tick is high for exactly one cycle at that edge.
- Glitch rejection:
  - Stimulus: sw high for 4 cycles, then low.
  - Required: db_level stays 0 and db_tick stays 0 throughout.
- Threshold acceptance:
  - Stimulus: sw high for 5 cycles, then low.
  - Required: db_level rises and db_tick pulses once. db_level falls 7 edges after sw drops, with no tick.
- Release bounce:
  - Stimulus: from db_level=1, sw toggles 1-0-1-0 with 2-cycle periods, then stays 0.
  - Required: db_level stays 1 until 7 edges after the final fall, then reads 0. No tick is asserted.
- Reset mid-wait:
  - Stimulus: sw held high; assert reset asynchronously 2 cycles after the FSM enters WAIT1.
  - Required: db_level=0 and db_tick=0 immediately. After release with sw still high, db_level rises at the 7th edge after release.
- Edge-detector integration:
  - Stimulus: connect db_level to the dual edge detector; apply a bouncy press followed by a bouncy release.
  - Required: the detector produces exactly two ticks.

Source files
------------

// File: rtl/debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : debouncer
//  Purpose  : Two-flop synchronizer followed by a four-state counting FSM that
//             accepts a new switch level only after CNT_MAX+1 steady samples,
//             plus a one-cycle tick on every confirmed rising transition.
//  Revision : 1.0  initial release
// ============================================================================
module debouncer #(
  parameter int CNT_MAX = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_ZERO  = 2'd0;
  localparam logic [1:0] ST_WAIT1 = 2'd1;
  localparam logic [1:0] ST_ONE   = 2'd2;
  localparam logic [1:0] ST_WAIT0 = 2'd3;

  logic          s1_q;
  logic          sync_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // State register; synchronizer flops share the same asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= ST_ZERO;
      cnt_q   <= CNT_ZERO;
      tick_q  <= 1'b0;
    end else begin
      s1_q    <= sw;
      sync_q  <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state logic; the level check always wins over the counter reaching 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_ZERO: begin
        if (sync_q) begin
          state_d = ST_WAIT1;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT1: begin
        if (!sync_q) begin
          state_d = ST_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ST_ONE;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ONE: begin
        if (!sync_q) begin
          state_d = ST_WAIT0;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT0: begin
        if (sync_q) begin
          state_d = ST_ONE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ST_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_ZERO;
      end
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    db_level = (state_q == ST_ONE) || (state_q == ST_WAIT0);
    db_tick  = tick_q;
  end

endmodule
`default_nettype wire
